// File: rtl/tpu_mem_pkg.sv
// Shared definitions for the scratchpad memory path: requester ids, the
// arbiter state encoding and packed-bus slice helpers.
package tpu_mem_pkg;

  localparam int REQ_DMA_WR = 0;
  localparam int REQ_DMA_RD = 1;
  localparam int REQ_COMP   = 2;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // LSB position of requester idx inside a packed bus of width-bit slices.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/bram_port_arbiter_rr_pick.sv
// Combinational rotate-priority picker: grants the first set request found
// when scanning upward from start_i, wrapping at N-1 back to 0.
module rr_pick #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] start_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  always_comb begin : pick
    int cand;
    logic [IDW-1:0] cand_idx;
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int k = 0; k < N; k++) begin
      // start_i is always < N, so one subtraction keeps cand in range
      cand = int'(start_i) + k;
      if (cand >= N) cand = cand - N;
      cand_idx = IDW'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares the single-port data BRAM between DMA write, DMA read and compute
// requesters: round-robin grant, bounded burst lock, tagged read return.
//
// Handshake: a beat transfers on req_valid[i] & req_ready[i]; req_ready is
// combinational, one-hot or zero, and an unaccepted requester holds valid,
// we, addr and wdata stable. Read responses are never back-pressured.
module bram_port_arbiter
  import tpu_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 3,
  parameter int RD_LATENCY = 1,
  parameter int MAX_LOCK   = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]           rsp_data,
  output logic                            bram_en,
  output logic                            bram_we,
  output logic [ADDR_WIDTH-1:0]           bram_addr,
  output logic [DATA_WIDTH-1:0]           bram_din,
  input  logic [DATA_WIDTH-1:0]           bram_dout,
  output logic [$clog2(NUM_REQ)-1:0]      grant_id,
  output logic                            locked
);

  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(MAX_LOCK + 1);

  arb_state_t                         state_q;
  logic [IDW-1:0]                     last_grant_q;
  logic [IDW-1:0]                     owner_q;
  logic [CNTW-1:0]                    lock_cnt_q;
  logic [IDW-1:0]                     grant_id_q;
  logic [RD_LATENCY-1:0]              rd_v_q;
  logic [RD_LATENCY-1:0][IDW-1:0]     rd_tag_q;

  logic [IDW-1:0]     start_ptr;
  logic [NUM_REQ-1:0] pick_gnt;
  logic [IDW-1:0]     pick_idx;
  logic               pick_any;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     win;
  logic               xfer;
  logic [CNTW-1:0]    lock_cnt_inc;
  logic               at_limit;
  logic               rsp_live;

  // Explicit wrap so a non-power-of-two NUM_REQ never points at an unused slot
  always_comb begin
    start_ptr = '0;
    if (last_grant_q != IDW'(NUM_REQ - 1)) start_ptr = last_grant_q + 1'b1;
  end

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (IDW)
  ) u_pick (
    .req_i   (req_valid),
    .start_i (start_ptr),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  always_comb begin
    gnt = '0;
    win = pick_idx;
    if (state_q == ARB_LOCKED) begin
      win = owner_q;
      if (req_valid[owner_q]) gnt[owner_q] = 1'b1;
    end else if (pick_any) begin
      gnt = pick_gnt;
    end
    // Nothing may reach the BRAM while reset is held
    if (!rst_n) gnt = '0;
  end

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign bram_en   = xfer;

  always_comb begin
    bram_we   = 1'b0;
    bram_addr = '0;
    bram_din  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        bram_we   = req_we[i];
        bram_addr = req_addr[slice_lsb(i, ADDR_WIDTH) +: ADDR_WIDTH];
        bram_din  = req_wdata[slice_lsb(i, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // lock_cnt_q counts beats already taken by the owner; the beat that would
  // make it MAX_LOCK is the last one the owner gets before a forced release.
  assign lock_cnt_inc = lock_cnt_q + 1'b1;
  assign at_limit     = (lock_cnt_inc == CNTW'(MAX_LOCK));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= IDW'(NUM_REQ - 1);
      owner_q      <= '0;
      lock_cnt_q   <= '0;
      grant_id_q   <= '0;
    end else if (xfer) begin
      last_grant_q <= win;
      grant_id_q   <= win;
      case (state_q)
        ARB_IDLE: begin
          if (req_lock[win] && (MAX_LOCK > 1)) begin
            state_q    <= ARB_LOCKED;
            owner_q    <= win;
            lock_cnt_q <= CNTW'(1);
          end
        end
        ARB_LOCKED: begin
          if (!req_lock[win] || at_limit) begin
            state_q    <= ARB_IDLE;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_inc;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  // Read-tag pipe mirrors the BRAM read latency so data and tag line up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_v_q   <= '0;
      rd_tag_q <= '0;
    end else begin
      rd_v_q[0]   <= xfer & ~bram_we;
      rd_tag_q[0] <= win;
      for (int k = 1; k < RD_LATENCY; k++) begin
        rd_v_q[k]   <= rd_v_q[k-1];
        rd_tag_q[k] <= rd_tag_q[k-1];
      end
    end
  end

  assign rsp_live = rst_n & rd_v_q[RD_LATENCY-1];

  always_comb begin
    rsp_valid = '0;
    if (rsp_live) rsp_valid[rd_tag_q[RD_LATENCY-1]] = 1'b1;
  end

  assign rsp_data = rsp_live ? bram_dout : '0;
  assign grant_id = grant_id_q;
  assign locked   = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter: one instance with RD_LATENCY=1 and
// one with RD_LATENCY=2, each with a behavioural BRAM and response scoreboard.
module tb_bram_port_arbiter;
  import tpu_mem_pkg::*;

  localparam int AW = 13;
  localparam int DW = 32;
  localparam int NR = 3;
  localparam int ML = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // instance A (RD_LATENCY=1)
  logic [NR-1:0]    va, wea, lka, rdy_a, rv_a;
  logic [NR*AW-1:0] adra;
  logic [NR*DW-1:0] wda;
  logic [DW-1:0]    rd_a, bdin_a, bdout_a;
  logic             en_a, bwe_a, lkd_a;
  logic [AW-1:0]    badr_a;
  logic [1:0]       gid_a;

  // instance B (RD_LATENCY=2)
  logic [NR-1:0]    vb, web, lkb, rdy_b, rv_b;
  logic [NR*AW-1:0] adrb;
  logic [NR*DW-1:0] wdb;
  logic [DW-1:0]    rd_b, bdin_b, bdout_b, pipe_b;
  logic             en_b, bwe_b, lkd_b;
  logic [AW-1:0]    badr_b;
  logic [1:0]       gid_b;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR),
                      .RD_LATENCY(1), .MAX_LOCK(ML)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(va), .req_ready(rdy_a), .req_we(wea),
    .req_lock(lka), .req_addr(adra), .req_wdata(wda), .rsp_valid(rv_a),
    .rsp_data(rd_a), .bram_en(en_a), .bram_we(bwe_a), .bram_addr(badr_a),
    .bram_din(bdin_a), .bram_dout(bdout_a), .grant_id(gid_a), .locked(lkd_a)
  );

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR),
                      .RD_LATENCY(2), .MAX_LOCK(ML)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vb), .req_ready(rdy_b), .req_we(web),
    .req_lock(lkb), .req_addr(adrb), .req_wdata(wdb), .rsp_valid(rv_b),
    .rsp_data(rd_b), .bram_en(en_b), .bram_we(bwe_b), .bram_addr(badr_b),
    .bram_din(bdin_b), .bram_dout(bdout_b), .grant_id(gid_b), .locked(lkd_b)
  );

  function automatic logic [DW-1:0] pattern(input int a);
    return 32'hC0DE_0000 ^ DW'(a);
  endfunction

  // behavioural BRAMs
  logic [DW-1:0] mem_a [0:(1<<AW)-1];
  logic [DW-1:0] mem_b [0:(1<<AW)-1];
  initial begin
    for (int i = 0; i < (1 << AW); i++) begin
      mem_a[i] = pattern(i);
      mem_b[i] = pattern(i);
    end
  end
  always @(posedge clk) begin
    if (en_a) begin
      if (bwe_a) mem_a[badr_a] <= bdin_a;
      else       bdout_a <= mem_a[badr_a];
    end
  end
  always @(posedge clk) begin
    if (en_b) begin
      if (bwe_b) mem_b[badr_b] <= bdin_b;
      else       pipe_b <= mem_b[badr_b];
    end
    bdout_b <= pipe_b;
  end

  // reference memory: contents the bench itself wrote, else the init pattern
  logic [DW-1:0] ref_mem [int];
  function automatic logic [DW-1:0] model_rd(input int a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pattern(a);
  endfunction

  logic [NR+DW-1:0] exp_a_q[$];
  int               exp_a_cyc[$];
  logic [NR+DW-1:0] exp_b_q[$];
  int               exp_b_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // response monitors
  always @(negedge clk) begin : mon_a
    logic [NR+DW-1:0] e;
    int ec;
    chk("single_grant_a", 64'($countones(rdy_a) <= 1), 64'(1));
    if (|rv_a) begin
      if (exp_a_q.size() == 0) begin
        chk("unexpected_rsp_a", 64'(rv_a), 64'(0));
      end else begin
        e  = exp_a_q.pop_front();
        ec = exp_a_cyc.pop_front();
        chk("rsp_valid_a", 64'(rv_a), 64'(e[DW +: NR]));
        chk("rsp_data_a", 64'(rd_a), 64'(e[DW-1:0]));
        chk("rsp_cycle_a", 64'(cyc), 64'(ec));
      end
    end
  end

  always @(negedge clk) begin : mon_b
    logic [NR+DW-1:0] e;
    int ec;
    chk("single_grant_b", 64'($countones(rdy_b) <= 1), 64'(1));
    if (|rv_b) begin
      if (exp_b_q.size() == 0) begin
        chk("unexpected_rsp_b", 64'(rv_b), 64'(0));
      end else begin
        e  = exp_b_q.pop_front();
        ec = exp_b_cyc.pop_front();
        chk("rsp_valid_b", 64'(rv_b), 64'(e[DW +: NR]));
        chk("rsp_data_b", 64'(rd_b), 64'(e[DW-1:0]));
        chk("rsp_cycle_b", 64'(cyc), 64'(ec));
      end
    end
  end

  task automatic set_a(input int i, input bit v, input bit we, input bit lk,
                       input int addr, input logic [DW-1:0] d);
    va[i] = v; wea[i] = we; lka[i] = lk;
    adra[i*AW +: AW] = AW'(addr);
    wda[i*DW +: DW]  = d;
  endtask

  task automatic set_b(input int i, input bit v, input int addr);
    vb[i] = v; web[i] = 1'b0; lkb[i] = 1'b0;
    adrb[i*AW +: AW] = AW'(addr);
    wdb[i*DW +: DW]  = '0;
  endtask

  // One cycle on instance A: expect requester exp granted (-1 = none).
  task automatic grant_a(input string nm, input int exp, input bit push);
    logic [NR-1:0] oh;
    logic [AW-1:0] a;
    @(negedge clk);
    oh = '0;
    if (exp < 0) begin
      chk({nm, "_ready"}, 64'(rdy_a), 64'(0));
      chk({nm, "_en"}, 64'(en_a), 64'(0));
      chk({nm, "_addr"}, 64'(badr_a), 64'(0));
    end else begin
      oh[exp] = 1'b1;
      a = adra[exp*AW +: AW];
      chk({nm, "_ready"}, 64'(rdy_a), 64'(oh));
      chk({nm, "_en"}, 64'(en_a), 64'(1));
      chk({nm, "_we"}, 64'(bwe_a), 64'(wea[exp]));
      chk({nm, "_addr"}, 64'(badr_a), 64'(a));
      if (wea[exp]) begin
        chk({nm, "_din"}, 64'(bdin_a), 64'(wda[exp*DW +: DW]));
        ref_mem[int'(a)] = wda[exp*DW +: DW];
      end else if (push) begin
        exp_a_q.push_back({oh, model_rd(int'(a))});
        exp_a_cyc.push_back(cyc + 1);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic grant_b(input string nm, input int exp);
    logic [NR-1:0] oh;
    logic [AW-1:0] a;
    @(negedge clk);
    oh = '0;
    if (exp < 0) begin
      chk({nm, "_ready"}, 64'(rdy_b), 64'(0));
    end else begin
      oh[exp] = 1'b1;
      a = adrb[exp*AW +: AW];
      chk({nm, "_ready"}, 64'(rdy_b), 64'(oh));
      chk({nm, "_addr"}, 64'(badr_b), 64'(a));
      exp_b_q.push_back({oh, pattern(int'(a))});
      exp_b_cyc.push_back(cyc + 2);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    va = '0; wea = '0; lka = '0; adra = '0; wda = '0;
    vb = '0; web = '0; lkb = '0; adrb = '0; wdb = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_rsp_valid", 64'(rv_a), 64'(0));
    chk("rst_rsp_data", 64'(rd_a), 64'(0));
    chk("rst_grant_id", 64'(gid_a), 64'(0));
    chk("rst_locked", 64'(lkd_a), 64'(0));
    chk("rst_bram_en", 64'(en_a), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // all three read, held three cycles: grants 0,1,2 in order
    set_a(0, 1, 0, 0, 'h010, '0);
    set_a(1, 1, 0, 0, 'h020, '0);
    set_a(2, 1, 0, 0, 'h030, '0);
    grant_a("t1_g0", 0, 1);
    grant_a("t1_g1", 1, 1);
    grant_a("t1_g2", 2, 1);
    va = '0;
    grant_a("t1_idle", -1, 0);
    chk("t1_grant_id", 64'(gid_a), 64'(2));

    // write then read of the top address
    set_a(2, 1, 1, 0, 'h1FFF, 32'hDEAD_BEEF);
    grant_a("t2_wr", 2, 1);
    va = '0;
    set_a(0, 1, 0, 0, 'h1FFF, '0);
    grant_a("t2_rd", 0, 1);
    va = '0;
    grant_a("t2_idle", -1, 0);

    // requester 1 locked burst of 20 writes against two other writers
    set_a(0, 1, 1, 0, 'h200, 32'hAAAA_0000);
    set_a(2, 1, 1, 0, 'h300, 32'hBBBB_0000);
    for (int k = 0; k < 16; k++) begin
      set_a(1, 1, 1, 1, 'h100 + k, 32'h1111_0000 + k);
      grant_a("t3_lock_beat", 1, 1);
      chk("t3_locked", 64'(lkd_a), 64'(k < 15));
    end
    grant_a("t3_after_2", 2, 1);
    grant_a("t3_after_0", 0, 1);
    set_a(1, 1, 1, 1, 'h110, 32'h1111_0010);
    grant_a("t3_after_1", 1, 1);
    chk("t3_relocked", 64'(lkd_a), 64'(1));
    va[0] = 1'b0; va[2] = 1'b0;
    for (int k = 17; k < 20; k++) begin
      set_a(1, 1, 1, (k < 19), 'h100 + k, 32'h1111_0000 + k);
      grant_a("t3_tail", 1, 1);
    end
    chk("t3_released", 64'(lkd_a), 64'(0));
    chk("t3_grant_id", 64'(gid_a), 64'(1));
    va = '0;
    grant_a("t3_idle", -1, 0);

    // owner 0 pauses mid-burst while 1 waits
    set_a(0, 1, 1, 1, 'h400, 32'h4444_0000);
    set_a(1, 1, 1, 0, 'h500, 32'h5555_0000);
    grant_a("t4_b1", 0, 1);
    grant_a("t4_b2", 0, 1);
    chk("t4_locked", 64'(lkd_a), 64'(1));
    va[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      grant_a("t4_owner_idle", -1, 0);
      chk("t4_still_locked", 64'(lkd_a), 64'(1));
      chk("t4_lock_cnt", 64'(dut_a.lock_cnt_q), 64'(2));
    end
    set_a(0, 1, 1, 0, 'h402, 32'h4444_0002);
    grant_a("t4_release", 0, 1);
    chk("t4_unlocked", 64'(lkd_a), 64'(0));
    va[0] = 1'b0;
    grant_a("t4_next", 1, 1);
    va = '0;

    // read accepted, then reset: response is dropped, priority restarts at 0
    set_a(0, 1, 0, 0, 'h040, '0);
    grant_a("t5_rd", 0, 0);
    rst_n = 1'b0;
    set_a(0, 1, 0, 0, 'h050, '0);
    set_a(1, 1, 0, 0, 'h060, '0);
    set_a(2, 1, 0, 0, 'h070, '0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("t5_rsp_dropped", 64'(rv_a), 64'(0));
      chk("t5_ready_in_rst", 64'(rdy_a), 64'(0));
      chk("t5_en_in_rst", 64'(en_a), 64'(0));
      @(posedge clk); #1;
    end
    chk("t5_grant_id_rst", 64'(gid_a), 64'(0));
    rst_n = 1'b1;
    grant_a("t5_prio0", 0, 1);
    va = '0;
    grant_a("t5_idle", -1, 0);

    // RD_LATENCY=2 instance: reads 0,1,0 back-to-back
    set_b(0, 1, 'h080);
    set_b(1, 1, 'h090);
    grant_b("t6_g0", 0);
    grant_b("t6_g1", 1);
    set_b(0, 1, 'h084);
    grant_b("t6_g0b", 0);
    vb = '0;
    grant_b("t6_idle", -1);

    repeat (6) @(negedge clk);
    chk("drain_a", 64'(exp_a_q.size()), 64'(0));
    chk("drain_b", 64'(exp_b_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
